// File: rtl/seq_alu_pkg.sv
// Shared unit codes, FSM states and flag positions for seq_alu.
package seq_alu_pkg;

    localparam logic [2:0] UNIT_ADD   = 3'b000;
    localparam logic [2:0] UNIT_AND   = 3'b001;
    localparam logic [2:0] UNIT_SHIFT = 3'b010;
    localparam logic [2:0] UNIT_SRC   = 3'b011;
    localparam logic [2:0] UNIT_OR    = 3'b100;
    localparam logic [2:0] UNIT_XOR   = 3'b101;
    localparam logic [2:0] UNIT_MUL   = 3'b110;
    localparam logic [2:0] UNIT_ACC   = 3'b111;

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/seq_alu_mul.sv
// Iterative unsigned shift-add multiplier: the first partial product is taken
// on start, the rest one per cycle; done marks the last busy cycle.
module seq_alu_mul #(
    parameter int WIDTH = 8
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [2*WIDTH-1:0] mcand_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            mcand_q  <= '0;
            prod_q   <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else if (start) begin
            mcand_q  <= {{WIDTH{1'b0}}, a} << 1;
            prod_q   <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
            mplier_q <= b >> 1;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            if (cnt_q == CNT_W'(WIDTH-1)) begin
                busy_q <= 1'b0;
            end else begin
                if (mplier_q[0])
                    prod_q <= prod_q + mcand_q;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q + 1'b1;
            end
        end
    end

    assign busy    = busy_q;
    assign done    = busy_q && (cnt_q == CNT_W'(WIDTH-1));
    assign product = prod_q;

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU with registered result/flags; unit 110 multiplies iteratively
// when SEQ_ALU_MUL_EN is defined, otherwise it returns 0 in one cycle.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             req_valid_in,
    output logic             req_ready_out,
    input  logic [2:0]       unit_sel_in,
    input  logic             op_sel_in,
    input  logic [WIDTH-1:0] acc_in,
    input  logic [WIDTH-1:0] src_in,
    output logic             res_valid_out,
    input  logic             res_ready_in,
    output logic [WIDTH-1:0] alu_res_out,
    output logic [3:0]       flags_out
);

    state_t           state_q;
    logic [WIDTH-1:0] res_q;
    logic [3:0]       flags_q;
    logic             vld_q;
    logic             accept;
    logic             is_mul;

    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic [SHAMT_W-1:0] shamt;

    function automatic logic [3:0] mk_flags(input logic [WIDTH-1:0] r, input logic c, input logic v);
        logic [3:0] f;
        f         = '0;
        f[FLAG_Z] = (r == '0);
        f[FLAG_N] = r[WIDTH-1];
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

    assign req_ready_out = (state_q == IDLE) || (state_q == DONE && res_ready_in);
    assign accept        = req_valid_in && req_ready_out;

`ifdef SEQ_ALU_MUL_EN
    logic               mul_busy;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;
    logic               mul_hi_q;
    logic [WIDTH-1:0]   mul_half;

    assign is_mul   = (unit_sel_in == UNIT_MUL);
    assign mul_half = mul_hi_q ? mul_prod[2*WIDTH-1:WIDTH] : mul_prod[WIDTH-1:0];

    seq_alu_mul #(.WIDTH(WIDTH)) u_mul (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .start    (accept && is_mul),
        .a        (acc_in),
        .b        (src_in),
        .busy     (mul_busy),
        .done     (mul_done),
        .product  (mul_prod)
    );
`else
    assign is_mul = 1'b0;
`endif

    assign shamt = src_in[SHAMT_W-1:0];

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        b_eff   = op_sel_in ? ~src_in : src_in;
        sum     = {1'b0, acc_in} + {1'b0, b_eff} + {{WIDTH{1'b0}}, op_sel_in};
        case (unit_sel_in)
            UNIT_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (acc_in[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != acc_in[WIDTH-1]);
            end
            UNIT_AND:   alu_res = op_sel_in ? ~(acc_in & src_in) : (acc_in & src_in);
            UNIT_SHIFT: begin
                // Only reachable for non-power-of-two widths.
                if ({1'b0, shamt} >= (SHAMT_W+1)'(WIDTH))
                    alu_res = '0;
                else
                    alu_res = op_sel_in ? (acc_in >> shamt) : (acc_in << shamt);
            end
            UNIT_SRC:   alu_res = src_in;
            UNIT_OR:    alu_res = acc_in | src_in;
            UNIT_XOR:   alu_res = acc_in ^ src_in;
            UNIT_ACC:   alu_res = acc_in;
            default:    alu_res = '0;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q  <= IDLE;
            res_q    <= '0;
            flags_q  <= '0;
            vld_q    <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
            mul_hi_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (state_q == IDLE || res_ready_in) begin
                        if (accept && is_mul) begin
                            state_q  <= MUL;
                            vld_q    <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
                            mul_hi_q <= op_sel_in;
`endif
                        end else if (accept) begin
                            state_q <= DONE;
                            vld_q   <= 1'b1;
                            res_q   <= alu_res;
                            flags_q <= mk_flags(alu_res, alu_c, alu_v);
                        end else begin
                            state_q <= IDLE;
                            vld_q   <= 1'b0;
                        end
                    end
                end
`ifdef SEQ_ALU_MUL_EN
                MUL: begin
                    if (mul_done) begin
                        state_q <= DONE;
                        vld_q   <= 1'b1;
                        res_q   <= mul_half;
                        flags_q <= mk_flags(mul_half, 1'b0, 1'b0);
                    end else if (!mul_busy) begin
                        // Multiplier lost its op; never strand the FSM in MUL.
                        state_q <= IDLE;
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    assign res_valid_out = vld_q;
    assign alu_res_out   = res_q;
    assign flags_out     = flags_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed plus random bench for seq_alu (WIDTH=8), arithmetic reference model.
module tb_seq_alu;

    localparam int W  = 8;
    localparam int SH = $clog2(W);
`ifdef SEQ_ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         res_ready = 1'b1;
    logic         op_sel = 1'b0;
    logic [2:0]   unit = 3'b000;
    logic [W-1:0] acc = '0;
    logic [W-1:0] src = '0;
    logic         req_ready;
    logic         res_valid;
    logic [W-1:0] res;
    logic [3:0]   flags;

    int vectors = 0;
    int miscompares = 0;
    logic [W-1:0] last_res;
    logic [3:0]   last_flags;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(W)) dut (
        .clk_in        (clk),
        .rst_n_in      (rst_n),
        .req_valid_in  (req_valid),
        .req_ready_out (req_ready),
        .unit_sel_in   (unit),
        .op_sel_in     (op_sel),
        .acc_in        (acc),
        .src_in        (src),
        .res_valid_out (res_valid),
        .res_ready_in  (res_ready),
        .alu_res_out   (res),
        .flags_out     (flags)
    );

    // Returns {result, Z, N, C, V} from plain integer arithmetic.
    function automatic logic [W+3:0] ref_model(input int u, input int o, input int a, input int b);
        int r, sa, sb, sr, amt, mask;
        longint p;
        bit c, v, z, n;
        mask = (1 << W) - 1;
        r = 0; c = 0; v = 0;
        case (u)
            0: begin
                r  = o ? a + (1 << W) - b : a + b;
                c  = (r >= (1 << W));
                r  = r & mask;
                sa = (a >= (1 << (W-1))) ? a - (1 << W) : a;
                sb = (b >= (1 << (W-1))) ? b - (1 << W) : b;
                sr = o ? sa - sb : sa + sb;
                v  = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
            end
            1: r = o ? (~(a & b)) & mask : a & b;
            2: begin
                amt = b % (1 << SH);
                r   = (amt >= W) ? 0 : (o ? a >> amt : (a << amt) & mask);
            end
            3: r = b;
            4: r = a | b;
            5: r = a ^ b;
            6: begin
                p = longint'(a) * longint'(b);
                r = !MUL_EN ? 0 : (o ? int'(p >> W) : int'(p) & mask);
            end
            default: r = a;
        endcase
        z = (r == 0);
        n = ((r >> (W-1)) & 1) != 0;
        return {r[W-1:0], z, n, c, v};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_op(input logic [2:0] u, input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W+3:0] e;
        int lat, exp_lat;
        e       = ref_model(int'(u), int'(o), int'(a), int'(b));
        exp_lat = (MUL_EN && u == 3'b110) ? W + 1 : 1;
        @(negedge clk);
        unit = u; op_sel = o; acc = a; src = b; req_valid = 1'b1;
        #1 check("req_ready_idle", 32'(req_ready), 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0; acc = ~a; src = ~b; unit = 3'b101; op_sel = ~o;
        lat = 1;
        while (res_valid !== 1'b1 && lat <= W + 4) begin
            check("ready_low_busy", 32'(req_ready), 0);
            @(posedge clk);
            #1 lat++;
        end
        check("latency", lat, exp_lat);
        check("result", 32'(res), 32'(e[W+3:4]));
        check("flags", 32'(flags), 32'(e[3:0]));
        last_res   = res;
        last_flags = flags;
        if (res_ready) begin
            @(posedge clk);
            #1 check("valid_drop", 32'(res_valid), 0);
        end
    endtask

    initial begin
        #12;
        check("rst_valid", 32'(res_valid), 0);
        check("rst_res", 32'(res), 0);
        check("rst_flags", 32'(flags), 0);
        check("rst_ready", 32'(req_ready), 1);
        @(negedge clk) rst_n = 1'b1;

        do_op(3'b000, 1'b0, 8'h7F, 8'h01);
        check("add_res", 32'(last_res), 32'h80);
        check("add_flags", 32'(last_flags), 32'b0101);
        do_op(3'b000, 1'b1, 8'h05, 8'h05);
        check("sub_eq_flags", 32'(last_flags), 32'b1010);
        do_op(3'b000, 1'b1, 8'h03, 8'h05);
        check("sub_borrow", 32'(last_res), 32'hFE);
        do_op(3'b010, 1'b1, 8'h96, 8'h03);
        check("shr", 32'(last_res), 32'h12);
        do_op(3'b010, 1'b0, 8'h96, 8'h03);
        check("shl", 32'(last_res), 32'hB0);
        do_op(3'b010, 1'b0, 8'h96, 8'h00);
        check("sh0", 32'(last_res), 32'h96);
        do_op(3'b001, 1'b1, 8'hF0, 8'h3C);
        check("nand", 32'(last_res), 32'hCF);
        do_op(3'b110, 1'b0, 8'h0F, 8'h11);
        check("mul_lo", 32'(last_res), MUL_EN ? 32'hFF : 32'h00);
        do_op(3'b110, 1'b1, 8'h0F, 8'h11);
        check("mul_hi", 32'(last_res), 32'h00);
        do_op(3'b110, 1'b0, 8'hFF, 8'hFF);
        check("mul_lo_ff", 32'(last_res), MUL_EN ? 32'h01 : 32'h00);
        do_op(3'b110, 1'b1, 8'hFF, 8'hFF);
        check("mul_hi_ff", 32'(last_res), MUL_EN ? 32'hFE : 32'h00);

        // Backpressure, then back-to-back accept on consume.
        res_ready = 1'b0;
        do_op(3'b101, 1'b0, 8'hAA, 8'hFF);
        for (int i = 0; i < 5; i++) begin
            check("bp_res", 32'(res), 32'h55);
            check("bp_valid", 32'(res_valid), 1);
            check("bp_ready", 32'(req_ready), 0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        res_ready = 1'b1; req_valid = 1'b1; unit = 3'b000; op_sel = 1'b0; acc = 8'h03; src = 8'h04;
        #1 check("b2b_ready", 32'(req_ready), 1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        check("b2b_valid", 32'(res_valid), 1);
        check("b2b_res", 32'(res), 32'h07);
        check("b2b_flags", 32'(flags), 0);
        @(posedge clk);
        #1 check("b2b_drop", 32'(res_valid), 0);

        // Reset mid-operation: in MUL cycle 4 with the multiplier, else while holding a result.
        @(negedge clk);
        if (!MUL_EN) res_ready = 1'b0;
        req_valid = 1'b1; unit = MUL_EN ? 3'b110 : 3'b100; op_sel = 1'b0; acc = 8'hFF; src = 8'h0F;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(res_valid), 0);
        check("arst_res", 32'(res), 0);
        check("arst_flags", 32'(flags), 0);
        check("arst_ready", 32'(req_ready), 1);
        @(negedge clk);
        rst_n = 1'b1; res_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1 check("no_result_after_abort", 32'(res_valid), 0);
        do_op(3'b000, 1'b0, 8'h01, 8'h01);
        check("post_rst_add", 32'(last_res), 32'h02);

        for (int i = 0; i < 60; i++)
            do_op(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised, handshaked successor to the core 8-bit ALU.
- Executes add/sub, and/nand, logical barrel shifts, pass, or, xor and pass-acc in one registered cycle.
- Adds an iterative unsigned multiplier on the previously unused unit code 3'b110.
- Produces Z/N/C/V flags.
- Sits between the accumulator/register-file read stage and writeback; valid/ready on both sides lets the control FSM stall on multi-cycle ops.

Parameters:
WIDTH, 8, datapath width in bits; any value >= 4.
SHAMT_W, $clog2(WIDTH), number of src bits used as shift amount.

Ports:
clk_in  input  1  clock, rising edge.
rst_n_in  input  1  reset; asynchronous assert, active-low.
req_valid_in  input  1  request valid.
req_ready_out  output  1  block can accept a request this cycle.
unit_sel_in  input  3  operation unit select.
op_sel_in  input  1  operation modifier.
acc_in  input  WIDTH  accumulator operand.
src_in  input  WIDTH  source operand.
res_valid_out  output  1  result and flags valid.
res_ready_in  input  1  consumer accepts result.
alu_res_out  output  WIDTH  registered result.
flags_out  output  4  {Z,N,C,V}, registered with result.

Behaviour:
- Reset (rst_n_in low, asynchronous): state=IDLE; res_valid_out=0; alu_res_out=0; flags_out=0; multiplier registers and counter=0. Reset mid-multiply aborts the op; no result is emitted.
- Transfers: request accepted when req_valid_in && req_ready_out; result consumed when res_valid_out && res_ready_in.
- req_ready_out = (state==IDLE) || (state==DONE && res_ready_in). This allows back-to-back single-cycle ops at full throughput.
- States:
  - IDLE: on accept of unit 110 -> MUL; on accept of any other unit -> DONE.
  - MUL: counter runs 0..WIDTH-1 -> DONE after WIDTH cycles. req_ready_out=0.
  - DONE: res_valid_out=1. On consume: if a new request is accepted in the same cycle, go to MUL or DONE per the rules above; otherwise go to IDLE.
- Result and flags are held stable while res_valid_out && !res_ready_in.
- Latency: single-cycle ops give res_valid_out the cycle after accept; MUL gives res_valid_out WIDTH+1 cycles after accept.
- Operations:
  - 000 add/sub: op_sel=0 gives acc+src; op_sel=1 gives acc+~src+1. C = carry-out (1 = no borrow on sub). V = signed overflow.
  - 001: and; op_sel=1 gives nand.
  - 010 logical shift by src[SHAMT_W-1:0]: op_sel=0 left, op_sel=1 right; zero fill. Amount 0 passes acc. Amounts >= WIDTH are not reachable when WIDTH is a power of two; otherwise they give 0.
  - 011: src. 100: or. 101: xor. 111: acc.
  - 110 multiply: unsigned 2*WIDTH product via shift-add, one partial product per cycle. op_sel=0 returns the low half, op_sel=1 the high half.
- Flags: Z = result==0; N = result MSB. For every op except add/sub, C=0 and V=0.
- Operands are captured at accept; input changes afterwards are ignored.

Optional Feature:
SEQ_ALU_MUL_EN.
- Defined: unit 110 multiplies as above.
- Undefined: no multiplier hardware. Unit 110 behaves as a single-cycle op returning 0 with Z=1 and other flags 0. The MUL state is never entered.

Decomposition:
- Package seq_alu_pkg:
  - unit codes UNIT_ADD=3'b000, UNIT_AND, UNIT_SHIFT, UNIT_SRC, UNIT_OR, UNIT_XOR, UNIT_MUL=3'b110, UNIT_ACC=3'b111;
  - state typedef {IDLE, MUL, DONE};
  - flag bit indices FLAG_Z=3, FLAG_N=2, FLAG_C=1, FLAG_V=0.
- Sub-module seq_alu_mul:
  - inputs start, a, b; outputs busy, done, product[2*WIDTH-1:0];
  - instantiated only under SEQ_ALU_MUL_EN.
- The single-cycle datapath stays in seq_alu.

Test Plan (WIDTH=8):
- ADD 0x7F+0x01, op_sel=0 -> res 0x80, flags Z0 N1 C0 V1, res_valid_out exactly 1 cycle after accept.
- SUB 0x05-0x05, op_sel=1 -> res 0x00, Z1 N0 C1 V0. SUB 0x03-0x05 -> 0xFE, N1 C0.
- SHIFT acc=0x96, src=3: op_sel=1 -> 0x12; op_sel=0 -> 0xB0. src=0 -> 0x96. NAND 0xF0,0x3C -> 0xCF.
- MUL (macro on):
  - 0x0F*0x11: low -> 0xFF, high -> 0x00.
  - 0xFF*0xFF: low -> 0x01, high -> 0xFE.
  - res_valid_out 9 cycles after accept; req_ready_out=0 throughout MUL.
- Backpressure: hold res_ready_in=0 for 5 cycles after an XOR 0xAA^0xFF -> 0x55 stable, req_ready_out=0. Then raise res_ready_in with a new request -> accepted the same cycle, next result the following cycle.
- Reset: assert rst_n_in low during MUL cycle 4 -> all outputs 0 immediately, state IDLE. After release, ADD 0x01+0x01 -> 0x02 with normal latency.
